// File: rtl/dlfloat_dot_engine.sv
// Streaming DLFloat16 dot-product engine: a product register feeding an accumulator,
// with a small handshake FSM that releases one result per VEC_LEN operand pairs.
module dlfloat_dot_engine #(
   parameter int unsigned VEC_LEN = 4,
   parameter bit          SAT_EN  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_ovf,
   output logic        busy
);

   localparam int unsigned CW = 8;
   localparam logic [15:0] NAN = 16'hFFFF;

   typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;

   state_t        state, next_state;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [15:0]   prod, acc;
   logic          ovf;
   logic          beat, hs;
   logic [16:0]   mul_res, add_res;

   // Range-check a normalized result; bit 16 of the return flags an overflow.
   function automatic logic [16:0] pack(input logic s, input logic signed [9:0] e,
                                        input logic [8:0] m);
      logic [16:0] r;
      if (e < 10'sd1)
         r = 17'd0;
      else if (e > 10'sd63)
         r = SAT_EN ? {1'b1, s, 6'd63, 9'd510} : {1'b1, s, e[5:0], m};
      else
         r = {1'b0, s, e[5:0], m};
      return r;
   endfunction

   function automatic logic [16:0] fmul(input logic [15:0] a, input logic [15:0] b);
      logic [19:0]        p;
      logic signed [9:0]  e;
      logic [8:0]         m;
      logic [16:0]        r;
      p = 20'({1'b1, a[8:0]}) * 20'({1'b1, b[8:0]});
      e = $signed({4'b0, a[14:9]}) + $signed({4'b0, b[14:9]}) - 10'sd31
          + (p[19] ? 10'sd1 : 10'sd0);
      m = 9'(p >> (p[19] ? 5'd10 : 5'd9));
      if (a == NAN || b == NAN)
         r = {1'b0, NAN};
      else if (a[14:9] == 6'd0 || b[14:9] == 6'd0)
         r = 17'd0;
      else
         r = pack(a[15] ^ b[15], e, m);
      return r;
   endfunction

   function automatic logic [16:0] fadd(input logic [15:0] x, input logic [15:0] y);
      logic [15:0]       big, sml;
      logic [5:0]        d;
      logic [9:0]        mb, ms;
      logic [10:0]       sum;
      logic signed [9:0] e;
      logic [8:0]        m;
      logic [3:0]        lz;
      logic [16:0]       r;
      big = (x[14:0] >= y[14:0]) ? x : y;
      sml = (x[14:0] >= y[14:0]) ? y : x;
      d   = big[14:9] - sml[14:9];
      mb  = {1'b1, big[8:0]};
      ms  = (d > 6'd9) ? 10'd0 : ({1'b1, sml[8:0]} >> d);
      e   = $signed({4'b0, big[14:9]});
      sum = 11'd0;
      m   = 9'd0;
      lz  = 4'd0;
      if (x == NAN || y == NAN)
         r = {1'b0, NAN};
      else if (y[14:9] == 6'd0)
         r = {1'b0, x};
      else if (x[14:9] == 6'd0)
         r = {1'b0, y};
      else if (big[15] == sml[15]) begin
         sum = {1'b0, mb} + {1'b0, ms};
         m   = 9'(sum >> (sum[10] ? 4'd1 : 4'd0));
         e   = e + (sum[10] ? 10'sd1 : 10'sd0);
         r   = pack(big[15], e, m);
      end else begin
         sum = {1'b0, mb - ms};
         if (sum == 11'd0)
            r = 17'd0;
         else begin
            // Highest set bit wins, giving the shift that puts the leading one at bit 9.
            for (int i = 0; i < 10; i++)
               if (sum[i]) lz = 4'(9 - i);
            m = 9'(sum << lz);
            e = e - $signed({6'b0, lz});
            r = pack(big[15], e, m);
         end
      end
      return r;
   endfunction

   assign beat     = in_valid & in_ready;
   assign hs       = out_valid & out_ready;
   assign mul_res  = fmul(in_a, in_b);
   assign add_res  = fadd(acc, prod);
   assign out_data = acc;
   assign out_ovf  = ovf;

   // Next-state and beat counter.
   always_comb begin
      next_state = state;
      cnt_nxt    = cnt;
      case (state)
         IDLE, ACC: begin
            if (beat) begin
               if (cnt == CW'(VEC_LEN - 1)) begin
                  next_state = FLUSH;
                  cnt_nxt    = '0;
               end else begin
                  next_state = ACC;
                  cnt_nxt    = cnt + CW'(1);
               end
            end
         end
         FLUSH:   next_state = DONE;
         DONE:    if (hs) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Idle cycles load a zero product, so the accumulator only moves on real beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         prod      <= 16'd0;
         acc       <= 16'd0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state <= next_state;
         cnt   <= cnt_nxt;
         prod  <= beat ? mul_res[15:0] : 16'd0;
         if (hs) begin
            acc <= 16'd0;
            ovf <= 1'b0;
         end else begin
            acc <= add_res[15:0];
            ovf <= ovf | (beat & mul_res[16]) | add_res[16];
         end
         in_ready  <= (next_state == IDLE) || (next_state == ACC);
         out_valid <= (state == DONE) && !hs;
         busy      <= (next_state != IDLE);
      end
   end

endmodule

// File: tb/tb_dlfloat_dot_engine.sv
// Bench for dlfloat_dot_engine: three instances (VEC_LEN 4/2/1, SAT on/on/off) driven by
// a directed table, hand sequences and random vectors scored against an integer model.
module tb_dlfloat_dot_engine;

   localparam int NI = 3;
   localparam logic [23:0] VLP = {8'd1, 8'd2, 8'd4};
   localparam logic [2:0]  SEP = 3'b011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid [NI];
   logic        out_ready[NI];
   logic [15:0] in_a     [NI];
   logic [15:0] in_b     [NI];
   wire         in_ready [NI];
   wire         out_valid[NI];
   wire  [15:0] out_data [NI];
   wire         out_ovf  [NI];
   wire         busy     [NI];

   int total = 0;
   int bad   = 0;
   logic [15:0] qa[$], qb[$];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dlfloat_dot_engine #(.VEC_LEN(VLP[g*8 +: 8]), .SAT_EN(SEP[g])) u_dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .in_a(in_a[g]), .in_b(in_b[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]),
         .out_data(out_data[g]), .out_ovf(out_ovf[g]), .busy(busy[g])
      );
   end

   always #5 clk = ~clk;

   typedef struct {
      int               g;
      int               n;
      logic [3:0][15:0] a;
      logic [3:0][15:0] b;
      int               gap;
      logic [15:0]      d;
      logic             o;
   } vec_t;

   vec_t tbl[9];

   task automatic check(input string nm, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---- reference model: values as signed integers scaled by powers of two ----
   function automatic logic [16:0] m_pack(input bit s, input int e, input int m, input bit sat);
      if (e < 1) return 17'd0;
      if (e > 63) return sat ? {1'b1, s, 6'd63, 9'd510} : {1'b1, s, 6'(e % 64), 9'(m - 512)};
      return {1'b0, s, 6'(e), 9'(m - 512)};
   endfunction

   function automatic logic [16:0] m_mul(input logic [15:0] a, input logic [15:0] b, input bit sat);
      int ea, eb, p, k;
      if (a == 16'hFFFF || b == 16'hFFFF) return {1'b0, 16'hFFFF};
      ea = int'(a[14:9]);
      eb = int'(b[14:9]);
      if (ea == 0 || eb == 0) return 17'd0;
      p = (512 + int'(a[8:0])) * (512 + int'(b[8:0]));
      k = 0;
      while ((p >> (9 + k)) >= 1024) k++;
      return m_pack(a[15] ^ b[15], ea + eb - 31 + k, p >> (9 + k), sat);
   endfunction

   function automatic logic [16:0] m_add(input logic [15:0] x, input logic [15:0] y, input bit sat);
      int ex, ey, e, vx, vy, s, mag;
      if (x == 16'hFFFF || y == 16'hFFFF) return {1'b0, 16'hFFFF};
      ex = int'(x[14:9]);
      ey = int'(y[14:9]);
      if (ey == 0) return {1'b0, x};
      if (ex == 0) return {1'b0, y};
      e  = (ex > ey) ? ex : ey;
      vx = (e - ex > 15) ? 0 : (512 + int'(x[8:0])) >> (e - ex);
      vy = (e - ey > 15) ? 0 : (512 + int'(y[8:0])) >> (e - ey);
      if (x[15]) vx = -vx;
      if (y[15]) vy = -vy;
      s = vx + vy;
      if (s == 0) return 17'd0;
      mag = (s < 0) ? -s : s;
      while (mag >= 1024) begin mag = mag >> 1; e++; end
      while (mag < 512)   begin mag = mag << 1; e--; end
      return m_pack(s < 0, e, mag, sat);
   endfunction

   function automatic logic [16:0] model_dot(input bit sat);
      logic [15:0] acc = 16'd0;
      bit          o   = 1'b0;
      logic [16:0] p, r;
      foreach (qa[i]) begin
         p   = m_mul(qa[i], qb[i], sat);
         r   = m_add(acc, p[15:0], sat);
         o   = o | p[16] | r[16];
         acc = r[15:0];
      end
      return {o, acc};
   endfunction

   function automatic logic [15:0] rnd_op();
      int r;
      logic [5:0] e;
      r = $urandom_range(0, 31);
      if (r == 0) return 16'hFFFF;
      if (r == 1)     e = 6'd0;
      else if (r < 5) e = 6'($urandom_range(50, 63));
      else            e = 6'($urandom_range(24, 38));
      return {1'($urandom_range(0, 1)), e, 9'($urandom)};
   endfunction

   // ---- drivers ----
   task automatic send(input int g, input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      in_valid[g] = 1'b1;
      in_a[g] = a;
      in_b[g] = b;
      while (!in_ready[g] && n < 50) begin tick(); n++; end
      check("in_ready_wait", in_ready[g], 1);
      tick();
      in_valid[g] = 1'b0;
   endtask

   task automatic run_vec(input int g, input int gap, input int hold, input bit poke,
                          input logic [15:0] ed, input logic eo);
      int t;
      for (int i = 0; i < qa.size(); i++) begin
         if (i > 0) repeat (gap) tick();
         send(g, qa[i], qb[i]);
      end
      t = 0;
      while (!out_valid[g] && t < 20) begin tick(); t++; end
      check("latency", t, 2);
      check("out_data", out_data[g], ed);
      check("out_ovf", out_ovf[g], eo);
      for (int i = 0; i < hold; i++) begin
         in_valid[g] = poke;
         in_a[g] = rnd_op();
         in_b[g] = rnd_op();
         tick();
         check("hold_valid", out_valid[g], 1);
         check("hold_in_ready", in_ready[g], 0);
         check("hold_data", out_data[g], ed);
      end
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
      tick();
      out_ready[g] = 1'b0;
      check("post_valid", out_valid[g], 0);
      check("post_busy", busy[g], 0);
      check("post_in_ready", in_ready[g], 1);
   endtask

   function automatic vec_t mk(input int g, input int n, input logic [63:0] a, input logic [63:0] b,
                               input int gap, input logic [15:0] d, input logic o);
      vec_t v;
      v.g = g; v.n = n; v.a = a; v.b = b; v.gap = gap; v.d = d; v.o = o;
      return v;
   endfunction

   initial begin
      logic [16:0] exp_r;
      int g;
      // beats listed last-to-first: {beat3, beat2, beat1, beat0}
      tbl[0] = mk(0, 4, {4{16'h3E00}}, {4{16'h3E00}}, 0, 16'h4200, 1'b0);
      tbl[1] = mk(0, 4, {4{16'h4000}}, {4{16'h4000}}, 2, 16'h4600, 1'b0);
      tbl[2] = mk(1, 2, {32'h0, 16'hBE00, 16'h3E00}, {32'h0, 16'h3E00, 16'h3E00}, 0, 16'h0000, 1'b0);
      tbl[3] = mk(0, 4, {16'h3E00, 16'h4000, 16'hFFFF, 16'h3E00},
                        {16'hBE00, 16'h4000, 16'h3E00, 16'h3E00}, 0, 16'hFFFF, 1'b0);
      tbl[4] = mk(0, 4, {48'h0, 16'h7C00}, {48'h0, 16'h7C00}, 0, 16'h7FFE, 1'b1);
      tbl[5] = mk(2, 1, {48'h0, 16'h7C00}, {48'h0, 16'h7C00}, 0, 16'h3A00, 1'b1);
      tbl[6] = mk(0, 4, {32'h0, 16'h3E00, 16'h3F00}, {32'h0, 16'h3E00, 16'h3F00}, 1, 16'h4140, 1'b0);
      tbl[7] = mk(0, 4, {32'h0, 16'h3E00, 16'h0200}, {32'h0, 16'h3E00, 16'h0200}, 0, 16'h3E00, 1'b0);
      tbl[8] = mk(1, 2, {32'h0, 16'hBD00, 16'h3E00}, {32'h0, 16'h3E00, 16'h3E00}, 0, 16'h3A00, 1'b0);

      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_a[i] = 16'd0; in_b[i] = 16'd0;
      end
      #12;
      for (int i = 0; i < NI; i++) begin
         check("rst_in_ready", in_ready[i], 1);
         check("rst_out_valid", out_valid[i], 0);
         check("rst_out_data", out_data[i], 0);
         check("rst_out_ovf", out_ovf[i], 0);
         check("rst_busy", busy[i], 0);
      end
      rst_n = 1'b1;
      tick();

      foreach (tbl[k]) begin
         qa.delete(); qb.delete();
         for (int i = 0; i < tbl[k].n; i++) begin
            qa.push_back(tbl[k].a[i]);
            qb.push_back(tbl[k].b[i]);
         end
         run_vec(tbl[k].g, tbl[k].gap, 0, 1'b0, tbl[k].d, tbl[k].o);
      end

      // result held five cycles with in_valid asserted against a full engine
      qa.delete(); qb.delete();
      for (int i = 0; i < 4; i++) begin qa.push_back(16'h3E00); qb.push_back(16'h4000); end
      run_vec(0, 0, 5, 1'b1, 16'h4400, 1'b0);

      // reset in the middle of a vector
      send(0, 16'h4000, 16'h4000);
      send(0, 16'h4000, 16'h4000);
      rst_n = 1'b0;
      #2;
      check("midrst_valid", out_valid[0], 0);
      check("midrst_busy", busy[0], 0);
      check("midrst_data", out_data[0], 0);
      rst_n = 1'b1;
      tick();
      qa.delete(); qb.delete();
      for (int i = 0; i < 4; i++) begin qa.push_back(16'h3E00); qb.push_back(16'h3E00); end
      run_vec(0, 0, 0, 1'b0, 16'h4200, 1'b0);

      // random vectors against the model
      for (int it = 0; it < 60; it++) begin
         g = it % NI;
         qa.delete(); qb.delete();
         for (int i = 0; i < int'(VLP[g*8 +: 8]); i++) begin
            qa.push_back(rnd_op());
            qb.push_back(rnd_op());
         end
         exp_r = model_dot(SEP[g]);
         run_vec(g, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 exp_r[15:0], exp_r[16]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
